decoder_binario_seq: RTL and testbench

Registered, parametrised binary-to-one-hot decoder with a valid/ready input, selectable output polarity and an autonomous scan mode. DIRECT mode decodes each accepted index into a one-hot output. SCAN mode walks the one-hot output across all positions at a programmable rate, for strobing or multiplexed select lines. It is the clocked, generalised successor of the team's 4-to-16 combinational decoder, used wherever select lines must be glitch-free and timed.

---
 rtl/decoder_binario_pkg.sv | 29 ++
 rtl/decoder_scan_ctr.sv | 43 ++++
 rtl/decoder_binario_seq.sv | 117 +++++++++++
 tb/tb_decoder_binario_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/decoder_binario_pkg.sv
// Shared types and helpers for the registered binary-to-one-hot decoder.
// Helpers work on a maximum width; callers cast the result down to their size.
package decoder_binario_pkg;

    localparam int MAX_IN_W  = 8;
    localparam int MAX_OUT_W = 2 ** MAX_IN_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_IN_W-1:0] idx);
        logic [MAX_OUT_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [MAX_OUT_W-1:0] apply_pol(input logic [MAX_OUT_W-1:0] v,
                                                      input logic inv);
        return v ^ {MAX_OUT_W{inv}};
    endfunction

endpackage

// File: rtl/decoder_scan_ctr.sv
// Scan prescaler and index counter. Holds each index div+1 cycles and
// pulses wrap together with the last-to-first index step.
module decoder_scan_ctr #(
    parameter int IN_W  = 4,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic [IN_W-1:0]  idx,
    output logic             wrap,
    output logic             step
);

    logic [DIV_W-1:0] pre_reg;
    logic [IN_W-1:0]  idx_reg;
    logic             wrap_reg;

    // div is compared live, so lowering it mid-dwell ends the dwell at once.
    assign step = run && (pre_reg >= div);
    assign idx  = idx_reg;
    assign wrap = wrap_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            pre_reg  <= '0;
            idx_reg  <= '0;
            wrap_reg <= 1'b0;
        end else if (step) begin
            pre_reg  <= '0;
            idx_reg  <= idx_reg + IN_W'(1);
            wrap_reg <= (idx_reg == {IN_W{1'b1}});
        end else if (run) begin
            pre_reg  <= pre_reg + DIV_W'(1);
            wrap_reg <= 1'b0;
        end else begin
            wrap_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/decoder_binario_seq.sv
// Registered binary-to-one-hot decoder with valid/ready input, output
// polarity selection and an autonomous scan mode.
module decoder_binario_seq
    import decoder_binario_pkg::*;
#(
    parameter int  IN_W       = 4,
    parameter bit  ACTIVE_LOW = 1'b0,
    parameter int  DIV_W      = 8,
    localparam int OUT_W      = 2 ** IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [DIV_W-1:0] div,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic [IN_W-1:0]  out_idx,
    output logic             wrap
);

    state_t           state_reg, state_next;
    logic [OUT_W-1:0] out_reg, out_next;
    logic             out_valid_reg, out_valid_next;
    logic [IN_W-1:0]  out_idx_reg, out_idx_next;

    logic             scan_hold;
    logic [IN_W-1:0]  ctr_idx;
    logic             ctr_wrap;
    logic             ctr_step;
    logic [IN_W-1:0]  scan_idx;
    logic             xfer;

    function automatic logic [OUT_W-1:0] drive(input logic [IN_W-1:0] i);
        return OUT_W'(apply_pol(onehot(MAX_IN_W'(i)), ACTIVE_LOW));
    endfunction

    localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACTIVE_LOW}};

    assign in_ready = (state_reg == ST_DIRECT) && en && (mode == MODE_DIRECT);
    assign xfer     = in_valid && in_ready;

    // The counter only runs while SCAN is both current and next; any other
    // cycle clears it so SCAN entry always starts at index 0 without wrap.
    assign scan_hold = (state_reg == ST_SCAN) && (state_next == ST_SCAN);
    assign scan_idx  = ctr_step ? ctr_idx + IN_W'(1) : ctr_idx;

    decoder_scan_ctr #(
        .IN_W  (IN_W),
        .DIV_W (DIV_W)
    ) u_scan_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!scan_hold),
        .run   (scan_hold),
        .div   (div),
        .idx   (ctr_idx),
        .wrap  (ctr_wrap),
        .step  (ctr_step)
    );

    always_comb begin
        state_next     = en ? ((mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT) : ST_IDLE;
        out_next       = out_reg;
        out_valid_next = out_valid_reg;
        out_idx_next   = out_idx_reg;
        case (state_next)
            ST_DIRECT: begin
                if (state_reg != ST_DIRECT) begin
                    out_next       = INACTIVE;
                    out_valid_next = 1'b0;
                end else if (xfer) begin
                    out_next       = drive(in_data);
                    out_valid_next = 1'b1;
                    out_idx_next   = in_data;
                end
            end
            ST_SCAN: begin
                out_valid_next = 1'b1;
                if (state_reg != ST_SCAN) begin
                    out_idx_next = '0;
                    out_next     = drive('0);
                end else begin
                    out_idx_next = scan_idx;
                    out_next     = drive(scan_idx);
                end
            end
            default: begin
                out_next       = INACTIVE;
                out_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            out_reg       <= INACTIVE;
            out_valid_reg <= 1'b0;
            out_idx_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            out_idx_reg   <= out_idx_next;
        end
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign out_idx   = out_idx_reg;
    assign wrap      = ctr_wrap;

endmodule

// File: tb/tb_decoder_binario_seq.sv
// Directed bench for decoder_binario_seq; an ACTIVE_LOW twin shares all inputs.
module tb_decoder_binario_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_data = 4'h0;
    logic [7:0]  div = 8'd0;

    logic        in_ready, out_valid, wrap;
    logic [15:0] out;
    logic [3:0]  out_idx;
    logic        al_in_ready, al_out_valid, al_wrap;
    logic [15:0] al_out;
    logic [3:0]  al_out_idx;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decoder_binario_seq #(.IN_W(4), .ACTIVE_LOW(1'b0), .DIV_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .div(div), .out(out),
        .out_valid(out_valid), .out_idx(out_idx), .wrap(wrap)
    );

    decoder_binario_seq #(.IN_W(4), .ACTIVE_LOW(1'b1), .DIV_W(8)) dut_al (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(al_in_ready), .in_data(in_data), .div(div), .out(al_out),
        .out_valid(al_out_valid), .out_idx(al_out_idx), .wrap(al_wrap)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        n_cmp += 6;
        if (out !== 16'h0000)    begin n_err++; $display("FAIL reset_out: got %h want 0000", out); end
        if (out_valid !== 1'b0)  begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        if (out_idx !== 4'h0)    begin n_err++; $display("FAIL reset_idx: got %h want 0", out_idx); end
        if (wrap !== 1'b0)       begin n_err++; $display("FAIL reset_wrap: got %b want 0", wrap); end
        if (in_ready !== 1'b0)   begin n_err++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        if (al_out !== 16'hFFFF) begin n_err++; $display("FAIL reset_al_out: got %h want FFFF", al_out); end
        $display("reset: out=%h al_out=%h", out, al_out);
    endtask

    task automatic test_direct();
        logic [3:0]  vec_d [4] = '{4'h0, 4'h5, 4'hF, 4'h3};
        logic [15:0] vec_o [4] = '{16'h0001, 16'h0020, 16'h8000, 16'h0008};
        logic [15:0] vec_a [4] = '{16'hFFFE, 16'hFFDF, 16'h7FFF, 16'hFFF7};
        en = 1'b1; mode = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL idle_ready: got %b want 0", in_ready); end
        tick();
        n_cmp += 3;
        if (in_ready !== 1'b1)  begin n_err++; $display("FAIL direct_ready: got %b want 1", in_ready); end
        if (out !== 16'h0000)   begin n_err++; $display("FAIL direct_entry_out: got %h want 0000", out); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL direct_entry_valid: got %b want 0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = vec_d[i];
            tick();
            n_cmp += 4;
            if (out !== vec_o[i])     begin n_err++; $display("FAIL direct_out[%0d]: got %h want %h", i, out, vec_o[i]); end
            if (out_idx !== vec_d[i]) begin n_err++; $display("FAIL direct_idx[%0d]: got %h want %h", i, out_idx, vec_d[i]); end
            if (out_valid !== 1'b1)   begin n_err++; $display("FAIL direct_valid[%0d]: got %b want 1", i, out_valid); end
            if (al_out !== vec_a[i])  begin n_err++; $display("FAIL direct_al_out[%0d]: got %h want %h", i, al_out, vec_a[i]); end
            $display("direct xfer: data=%h out=%h al_out=%h idx=%h", in_data, out, al_out, out_idx);
        end
        in_valid = 1'b0; in_data = 4'hA;
        tick();
        n_cmp += 2;
        if (out !== 16'h0008)  begin n_err++; $display("FAIL direct_hold_out: got %h want 0008", out); end
        if (out_idx !== 4'h3)  begin n_err++; $display("FAIL direct_hold_idx: got %h want 3", out_idx); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_idx;
        logic       exp_wrap;
        int         nwrap = 0;
        mode = 1'b1; div = 8'd2;
        tick();
        n_cmp += 5;
        if (out !== 16'h0001)    begin n_err++; $display("FAIL scan_entry_out: got %h want 0001", out); end
        if (out_valid !== 1'b1)  begin n_err++; $display("FAIL scan_entry_valid: got %b want 1", out_valid); end
        if (wrap !== 1'b0)       begin n_err++; $display("FAIL scan_entry_wrap: got %b want 0", wrap); end
        if (in_ready !== 1'b0)   begin n_err++; $display("FAIL scan_ready: got %b want 0", in_ready); end
        if (al_out !== 16'hFFFE) begin n_err++; $display("FAIL scan_al_out: got %h want FFFE", al_out); end
        for (int c = 1; c <= 100; c++) begin
            tick();
            exp_idx  = 4'((c / 3) % 16);
            exp_wrap = (c % 48 == 0);
            n_cmp += 3;
            if (out_idx !== exp_idx)          begin n_err++; $display("FAIL scan_idx c=%0d: got %h want %h", c, out_idx, exp_idx); end
            if (out !== (16'h0001 << exp_idx)) begin n_err++; $display("FAIL scan_out c=%0d: got %h want %h", c, out, 16'h0001 << exp_idx); end
            if (wrap !== exp_wrap)            begin n_err++; $display("FAIL scan_wrap c=%0d: got %b want %b", c, wrap, exp_wrap); end
            if (wrap === 1'b1) begin
                nwrap++;
                $display("scan wrap at c=%0d out=%h", c, out);
            end
        end
        n_cmp++;
        if (nwrap !== 2) begin n_err++; $display("FAIL scan_wrap_count: got %0d want 2", nwrap); end
    endtask

    task automatic test_en_drop();
        en = 1'b0; tick();
        en = 1'b1; mode = 1'b1; div = 8'd0; tick();
        repeat (9) tick();
        n_cmp++;
        if (out_idx !== 4'h9) begin n_err++; $display("FAIL endrop_pre_idx: got %h want 9", out_idx); end
        en = 1'b0; tick();
        n_cmp += 3;
        if (out !== 16'h0000)   begin n_err++; $display("FAIL endrop_out: got %h want 0000", out); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL endrop_valid: got %b want 0", out_valid); end
        if (al_out !== 16'hFFFF) begin n_err++; $display("FAIL endrop_al_out: got %h want FFFF", al_out); end
        en = 1'b1; tick();
        n_cmp += 3;
        if (out !== 16'h0001) begin n_err++; $display("FAIL enrestart_out: got %h want 0001", out); end
        if (out_idx !== 4'h0) begin n_err++; $display("FAIL enrestart_idx: got %h want 0", out_idx); end
        if (wrap !== 1'b0)    begin n_err++; $display("FAIL enrestart_wrap: got %b want 0", wrap); end
        $display("en drop/restart: out=%h idx=%h", out, out_idx);
    endtask

    task automatic test_mode_race();
        mode = 1'b0; tick();
        n_cmp += 2;
        if (out !== 16'h0000) begin n_err++; $display("FAIL race_direct_out: got %h want 0000", out); end
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL race_direct_ready: got %b want 1", in_ready); end
        mode = 1'b1; in_valid = 1'b1; in_data = 4'h7;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL race_ready: got %b want 0", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp += 2;
        if (out !== 16'h0001) begin n_err++; $display("FAIL race_out: got %h want 0001", out); end
        if (out_idx !== 4'h0) begin n_err++; $display("FAIL race_idx: got %h want 0", out_idx); end
        $display("mode race: out=%h idx=%h", out, out_idx);
    endtask

    task automatic test_div_bounds();
        en = 1'b0; tick();
        en = 1'b1; mode = 1'b1; div = 8'd255; tick();
        repeat (255) tick();
        n_cmp++;
        if (out_idx !== 4'h0) begin n_err++; $display("FAIL divmax_hold: got %h want 0", out_idx); end
        tick();
        n_cmp++;
        if (out_idx !== 4'h1) begin n_err++; $display("FAIL divmax_step: got %h want 1", out_idx); end
        repeat (10) tick();
        n_cmp++;
        if (out_idx !== 4'h1) begin n_err++; $display("FAIL divlower_pre: got %h want 1", out_idx); end
        div = 8'd0; tick();
        n_cmp += 2;
        if (out_idx !== 4'h2) begin n_err++; $display("FAIL divlower_step: got %h want 2", out_idx); end
        if (out !== 16'h0004) begin n_err++; $display("FAIL divlower_out: got %h want 0004", out); end
        $display("div bounds: idx=%h", out_idx);
    endtask

    task automatic test_reset_mid_scan();
        repeat (13) tick();
        n_cmp++;
        if (out_idx !== 4'hF) begin n_err++; $display("FAIL rstscan_pre_idx: got %h want F", out_idx); end
        rst_n = 1'b0; tick();
        n_cmp += 5;
        if (out !== 16'h0000)   begin n_err++; $display("FAIL rstscan_out: got %h want 0000", out); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstscan_valid: got %b want 0", out_valid); end
        if (out_idx !== 4'h0)   begin n_err++; $display("FAIL rstscan_idx: got %h want 0", out_idx); end
        if (wrap !== 1'b0)      begin n_err++; $display("FAIL rstscan_wrap: got %b want 0", wrap); end
        if (in_ready !== 1'b0)  begin n_err++; $display("FAIL rstscan_ready: got %b want 0", in_ready); end
        $display("reset mid scan: out=%h wrap=%b", out, wrap);
        rst_n = 1'b1; en = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan();
        test_en_drop();
        test_mode_race();
        test_div_bounds();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
